multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the 32-bit RISC core. It replaces single-cycle decode with an FSM that steps each instruction through fetch, decode, execute, memory and writeback. It uses a ready handshake on the shared instruction/data memory, and drives the same datapath control signals as the combinational control unit plus PC/IR write enables. It sits between the instruction register's opcode field and the datapath muxes, register file, ALU and memory port.

---
 rtl/cpu_ctrl_pkg.sv | 57 +++++
 rtl/mem_wait_timer.sv | 47 ++++
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer:
// opcodes, ALU operations, FSM states and decode helpers.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_NOT = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b0111;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1110;
  localparam logic [3:0] OP_JMP = 4'b1111;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_NOT   = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  function automatic logic [2:0] alu_op(input logic [3:0] op);
    logic [2:0] r;
    case (op)
      OP_AND:         r = ALU_AND;
      OP_OR:          r = ALU_OR;
      OP_NOT:         r = ALU_NOT;
      OP_SUB, OP_BNE: r = ALU_SUB;
      OP_LDI:         r = ALU_PASSB;
      default:        r = ALU_ADD;
    endcase
    return r;
  endfunction

  function automatic logic is_rtype(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) ||
           (op == OP_ADD) || (op == OP_NOT) ||
           (op == OP_SUB);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return is_rtype(op) || (op == OP_LDI) ||
           (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BNE) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter with timeout detect
// and a sticky fault flag cleared only by reset.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_active,
  input  logic i_mem_ready,
  output logic o_timeout,
  output logic o_fault
);

  localparam int CW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CMAX = '1;

  logic [CW-1:0] r_cnt;
  logic          r_fault;
  logic          w_wait;

  assign w_wait    = i_active & ~i_mem_ready;
  assign o_timeout = (MEM_TIMEOUT != 0) && w_wait &&
                     (int'(r_cnt) == MEM_TIMEOUT - 1);
  assign o_fault   = r_fault;

  // count stalled cycles in a memory state, clear otherwise
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_cnt <= '0;
    end else if (!w_wait) begin
      r_cnt <= '0;
    end else if (r_cnt != CMAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // fault latches on the cycle the wait limit is hit
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_fault <= 1'b0;
    end else if (o_timeout) begin
      r_fault <= 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch, decode, exec,
// mem, writeback, with a memory-timeout halt state.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [3:0] Opcode,
  input  logic       Zero,
  input  logic       Mem_Ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IRWrite,
  output logic       RegDest,
  output logic       Jump,
  output logic       Branch,
  output logic       Sig_Mem_Read,
  output logic       Sig_Mem_to_Reg,
  output logic       Sig_Mem_Write,
  output logic       ALUSrc,
  output logic       Sig_Reg_Write,
  output logic [2:0] ALUOp,
  output logic       Instr_Done,
  output logic       Illegal_Op,
  output logic       Mem_Fault,
  output logic [2:0] State
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_op;
  logic       w_active;
  logic       w_timeout;
  logic       w_fault;

  logic       w_pcw, w_pcc, w_irw, w_rd, w_jmp, w_br;
  logic       w_mr, w_m2r, w_mw, w_as, w_rw;
  logic       w_done, w_ill;
  logic [2:0] w_alu;

  // branch resolution (Zero) happens in the datapath via PCWriteCond
  logic       w_zero_unused;
  assign w_zero_unused = Zero;

  assign w_active = (r_state == S_FETCH) ||
                    (r_state == S_MEM);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .i_active   (w_active),
    .i_mem_ready(Mem_Ready),
    .o_timeout  (w_timeout),
    .o_fault    (w_fault)
  );

  // state register and opcode latch captured in DECODE
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= S_FETCH;
      r_op    <= OP_AND;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= Opcode;
    end
  end

  // next-state and control decode
  always_comb begin
    w_next = r_state;
    w_pcw  = 1'b0;
    w_pcc  = 1'b0;
    w_irw  = 1'b0;
    w_rd   = 1'b0;
    w_jmp  = 1'b0;
    w_br   = 1'b0;
    w_mr   = 1'b0;
    w_m2r  = 1'b0;
    w_mw   = 1'b0;
    w_as   = 1'b0;
    w_rw   = 1'b0;
    w_done = 1'b0;
    w_ill  = 1'b0;
    w_alu  = 3'b000;
    unique case (r_state)
      S_FETCH: begin
        w_mr  = 1'b1;
        w_alu = ALU_ADD;
        if (Mem_Ready) begin
          w_irw  = 1'b1;
          w_pcw  = 1'b1;
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_HALT;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          (Opcode == OP_JMP): begin
            w_jmp  = 1'b1;
            w_pcw  = 1'b1;
            w_done = 1'b1;
            w_next = S_FETCH;
          end
          (!is_legal(Opcode)): begin
            w_ill  = 1'b1;
            w_done = 1'b1;
            w_next = S_FETCH;
          end
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        w_alu = alu_op(r_op);
        w_as  = (r_op == OP_LDI) || (r_op == OP_LW) ||
                (r_op == OP_SW);
        if (r_op == OP_BNE) begin
          w_br   = 1'b1;
          w_pcc  = 1'b1;
          w_done = 1'b1;
          w_next = S_FETCH;
        end else if ((r_op == OP_LW) || (r_op == OP_SW)) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_mr = (r_op == OP_LW);
        w_mw = (r_op == OP_SW);
        if (Mem_Ready) begin
          w_done = (r_op == OP_SW);
          w_next = (r_op == OP_LW) ? S_WB : S_FETCH;
        end else if (w_timeout) begin
          w_next = S_HALT;
        end
      end
      S_WB: begin
        w_rw   = 1'b1;
        w_rd   = is_rtype(r_op);
        w_m2r  = (r_op == OP_LW);
        w_alu  = alu_op(r_op);
        w_done = 1'b1;
        w_next = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  assign PCWrite        = Reset_n & w_pcw;
  assign PCWriteCond    = Reset_n & w_pcc;
  assign IRWrite        = Reset_n & w_irw;
  assign RegDest        = Reset_n & w_rd;
  assign Jump           = Reset_n & w_jmp;
  assign Branch         = Reset_n & w_br;
  assign Sig_Mem_Read   = Reset_n & w_mr;
  assign Sig_Mem_to_Reg = Reset_n & w_m2r;
  assign Sig_Mem_Write  = Reset_n & w_mw;
  assign ALUSrc         = Reset_n & w_as;
  assign Sig_Reg_Write  = Reset_n & w_rw;
  assign Instr_Done     = Reset_n & w_done;
  assign Illegal_Op     = Reset_n & w_ill;
  assign Mem_Fault      = Reset_n & w_fault;
  assign ALUOp          = Reset_n ? w_alu : 3'b000;
  assign State          = Reset_n ? r_state : 3'b000;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle
// stimulus and expected outputs queued, then replayed.
module tb_multicycle_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n, Zero, Mem_Ready;
  logic [3:0] Opcode;
  logic       PCWrite, PCWriteCond, IRWrite, RegDest, Jump, Branch;
  logic       Sig_Mem_Read, Sig_Mem_to_Reg, Sig_Mem_Write;
  logic       ALUSrc, Sig_Reg_Write, Instr_Done, Illegal_Op, Mem_Fault;
  logic [2:0] ALUOp, State;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Opcode(Opcode), .Zero(Zero),
    .Mem_Ready(Mem_Ready), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
    .RegDest(RegDest), .Jump(Jump), .Branch(Branch),
    .Sig_Mem_Read(Sig_Mem_Read), .Sig_Mem_to_Reg(Sig_Mem_to_Reg),
    .Sig_Mem_Write(Sig_Mem_Write), .ALUSrc(ALUSrc),
    .Sig_Reg_Write(Sig_Reg_Write), .ALUOp(ALUOp),
    .Instr_Done(Instr_Done), .Illegal_Op(Illegal_Op),
    .Mem_Fault(Mem_Fault), .State(State)
  );

  always #5 Clk = ~Clk;

  // control bits: PCW PCC IRW RD JMP BR MR M2R MW AS RW
  localparam logic [10:0] PCW = 11'b100_0000_0000;
  localparam logic [10:0] PCC = 11'b010_0000_0000;
  localparam logic [10:0] IRW = 11'b001_0000_0000;
  localparam logic [10:0] RD  = 11'b000_1000_0000;
  localparam logic [10:0] JMP = 11'b000_0100_0000;
  localparam logic [10:0] BR  = 11'b000_0010_0000;
  localparam logic [10:0] MR  = 11'b000_0001_0000;
  localparam logic [10:0] M2R = 11'b000_0000_1000;
  localparam logic [10:0] MW  = 11'b000_0000_0100;
  localparam logic [10:0] AS  = 11'b000_0000_0010;
  localparam logic [10:0] RW  = 11'b000_0000_0001;

  typedef struct {
    string       tag;
    logic        rn;
    logic        rdy;
    logic [3:0]  op;
    logic        z;
    logic [19:0] exp;
  } item_t;

  item_t q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  logic [19:0] w_obs;
  assign w_obs = {State, PCWrite, PCWriteCond, IRWrite, RegDest,
                  Jump, Branch, Sig_Mem_Read, Sig_Mem_to_Reg,
                  Sig_Mem_Write, ALUSrc, Sig_Reg_Write, ALUOp,
                  Instr_Done, Illegal_Op, Mem_Fault};

  function automatic item_t mk(
    input string tag, input logic rn, input logic rdy,
    input logic [3:0] op, input logic z,
    input logic [2:0] st, input logic [10:0] ctl,
    input logic [2:0] alu, input logic done,
    input logic ill, input logic flt);
    item_t t;
    t.tag = tag; t.rn = rn; t.rdy = rdy; t.op = op; t.z = z;
    t.exp = {st, ctl, alu, done, ill, flt};
    return t;
  endfunction

  // fetch cycle with memory ready, opcode on the bus is ignored
  function automatic item_t fetch_ok(input string tag);
    return mk(tag, 1, 1, 4'b0100, 0, 3'd0, PCW | IRW | MR,
              3'b010, 0, 0, 0);
  endfunction

  task automatic test_reset();
    q.push_back(mk("rst0", 0, 1, 4'b1111, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk("rst1", 0, 1, 4'b1111, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(fetch_ok("rst.fetch"));
    q.push_back(mk("rst.abort", 0, 1, 4'b0010, 0,
                   0, 0, 0, 0, 0, 0));
    while (q.size() > 0) begin
      item_t t;
      t = q.pop_front();
      @(negedge Clk);
      Reset_n = t.rn; Mem_Ready = t.rdy; Opcode = t.op; Zero = t.z;
      #1;
      n_chk++;
      if (w_obs !== t.exp)
        $display("FAIL %s: got %b want %b", t.tag, w_obs, t.exp);
      else n_pass++;
    end
  endtask

  task automatic test_add();
    q.push_back(fetch_ok("add.fetch"));
    q.push_back(mk("add.dec", 1, 1, 4'b0010, 0, 1, 0, 0, 0, 0, 0));
    q.push_back(mk("add.exe", 1, 0, 4'b1111, 0, 2, 0,
                   3'b010, 0, 0, 0));
    q.push_back(mk("add.wb", 1, 0, 4'b0100, 0, 4, RD | RW,
                   3'b010, 1, 0, 0));
    while (q.size() > 0) begin
      item_t t;
      t = q.pop_front();
      @(negedge Clk);
      Reset_n = t.rn; Mem_Ready = t.rdy; Opcode = t.op; Zero = t.z;
      #1;
      n_chk++;
      if (w_obs !== t.exp)
        $display("FAIL %s: got %b want %b", t.tag, w_obs, t.exp);
      else n_pass++;
    end
  endtask

  task automatic test_lw_wait();
    q.push_back(fetch_ok("lw.fetch"));
    q.push_back(mk("lw.dec", 1, 0, 4'b1000, 0, 1, 0, 0, 0, 0, 0));
    q.push_back(mk("lw.exe", 1, 0, 4'b0000, 0, 2, AS,
                   3'b010, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      q.push_back(mk($sformatf("lw.memwait%0d", i), 1, 0, 4'b0000,
                     0, 3, MR, 0, 0, 0, 0));
    q.push_back(mk("lw.memrdy", 1, 1, 4'b0000, 0, 3, MR,
                   0, 0, 0, 0));
    q.push_back(mk("lw.wb", 1, 1, 4'b0010, 0, 4, M2R | RW,
                   3'b010, 1, 0, 0));
    while (q.size() > 0) begin
      item_t t;
      t = q.pop_front();
      @(negedge Clk);
      Reset_n = t.rn; Mem_Ready = t.rdy; Opcode = t.op; Zero = t.z;
      #1;
      n_chk++;
      if (w_obs !== t.exp)
        $display("FAIL %s: got %b want %b", t.tag, w_obs, t.exp);
      else n_pass++;
    end
  endtask

  task automatic test_bne();
    for (int z = 0; z < 2; z++) begin
      q.push_back(fetch_ok($sformatf("bne%0d.fetch", z)));
      q.push_back(mk($sformatf("bne%0d.dec", z), 1, 1, 4'b1110,
                     z[0], 1, 0, 0, 0, 0, 0));
      q.push_back(mk($sformatf("bne%0d.exe", z), 1, 1, 4'b0011,
                     z[0], 2, BR | PCC, 3'b110, 1, 0, 0));
    end
    while (q.size() > 0) begin
      item_t t;
      t = q.pop_front();
      @(negedge Clk);
      Reset_n = t.rn; Mem_Ready = t.rdy; Opcode = t.op; Zero = t.z;
      #1;
      n_chk++;
      if (w_obs !== t.exp)
        $display("FAIL %s: got %b want %b", t.tag, w_obs, t.exp);
      else n_pass++;
    end
  endtask

  task automatic test_jmp_illegal();
    q.push_back(fetch_ok("jmp.fetch"));
    q.push_back(mk("jmp.dec", 1, 1, 4'b1111, 0, 1, JMP | PCW,
                   0, 1, 0, 0));
    q.push_back(fetch_ok("ill.fetch"));
    q.push_back(mk("ill.dec", 1, 1, 4'b0100, 0, 1, 0, 0, 1, 1, 0));
    q.push_back(fetch_ok("ill.next"));
    q.push_back(mk("ill2.dec", 1, 1, 4'b1011, 0, 1, 0, 0, 1, 1, 0));
    while (q.size() > 0) begin
      item_t t;
      t = q.pop_front();
      @(negedge Clk);
      Reset_n = t.rn; Mem_Ready = t.rdy; Opcode = t.op; Zero = t.z;
      #1;
      n_chk++;
      if (w_obs !== t.exp)
        $display("FAIL %s: got %b want %b", t.tag, w_obs, t.exp);
      else n_pass++;
    end
  endtask

  task automatic test_ldi_sw();
    q.push_back(fetch_ok("ldi.fetch"));
    q.push_back(mk("ldi.dec", 1, 1, 4'b0111, 0, 1, 0, 0, 0, 0, 0));
    q.push_back(mk("ldi.exe", 1, 1, 4'b1000, 0, 2, AS,
                   3'b111, 0, 0, 0));
    q.push_back(mk("ldi.wb", 1, 1, 4'b1000, 0, 4, RW,
                   3'b111, 1, 0, 0));
    q.push_back(mk("sw.fwait", 1, 0, 4'b0000, 0, 0, MR,
                   3'b010, 0, 0, 0));
    q.push_back(fetch_ok("sw.fetch"));
    q.push_back(mk("sw.dec", 1, 1, 4'b1010, 0, 1, 0, 0, 0, 0, 0));
    q.push_back(mk("sw.exe", 1, 1, 4'b0111, 0, 2, AS,
                   3'b010, 0, 0, 0));
    q.push_back(mk("sw.mem", 1, 1, 4'b0111, 0, 3, MW,
                   0, 1, 0, 0));
    while (q.size() > 0) begin
      item_t t;
      t = q.pop_front();
      @(negedge Clk);
      Reset_n = t.rn; Mem_Ready = t.rdy; Opcode = t.op; Zero = t.z;
      #1;
      n_chk++;
      if (w_obs !== t.exp)
        $display("FAIL %s: got %b want %b", t.tag, w_obs, t.exp);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    q.push_back(fetch_ok("to.fetch"));
    q.push_back(mk("to.dec", 1, 0, 4'b1010, 0, 1, 0, 0, 0, 0, 0));
    q.push_back(mk("to.exe", 1, 0, 4'b1010, 0, 2, AS,
                   3'b010, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      q.push_back(mk($sformatf("to.memwait%0d", i), 1, 0, 4'b1010,
                     0, 3, MW, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      q.push_back(mk($sformatf("to.halt%0d", i), 1, i[0], 4'b1111,
                     0, 7, 0, 0, 0, 0, 1));
    q.push_back(mk("to.rst", 0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(fetch_ok("to.recover"));
    while (q.size() > 0) begin
      item_t t;
      t = q.pop_front();
      @(negedge Clk);
      Reset_n = t.rn; Mem_Ready = t.rdy; Opcode = t.op; Zero = t.z;
      #1;
      n_chk++;
      if (w_obs !== t.exp)
        $display("FAIL %s: got %b want %b", t.tag, w_obs, t.exp);
      else n_pass++;
    end
  endtask

  initial begin
    Reset_n = 1'b0; Mem_Ready = 1'b1; Opcode = 4'b0000; Zero = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_bne();
    test_jmp_illegal();
    test_ldi_sw();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
